// File: rtl/ex_pkg.sv
// ----------------------------------------------------------------------------
// ex_pkg
// Shared constants for the execute stage of the ARM-subset pipeline.
//   WORD_W      : datapath width used by the execute stage helpers
//   CMD_*       : ALU command encodings carried in exe_cmd from decode
//   SH_*        : shift-type encodings found in shifter operand bits [6:5]
//   FLAG_*      : bit positions of N, Z, C, V inside the 4-bit status word
//   rotateRight : 32-bit rotate helper shared by the Val2 generator
// ----------------------------------------------------------------------------
package ex_pkg;

    localparam int WORD_W = 32;

    // ALU command encodings
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    // Register-operand shift types
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Status word bit positions, status = {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Rotating a doubled copy of the word lets a plain right shift pick out
    // the rotated result, including the zero-amount case.
    function automatic logic [WORD_W-1:0] rotateRight(input logic [WORD_W-1:0] x,
                                                      input logic [4:0]        amt);
        logic [2*WORD_W-1:0] doubled;
        doubled = {x, x} >> amt;
        return doubled[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/val2_gen.sv
// ----------------------------------------------------------------------------
// val2_gen
// Purely combinational generator of the second ALU operand (Val2).
// Ports:
//   memEn        in  1   load or store in flight; Val2 is the raw 12-bit offset
//   imm          in  1   immediate operand; 8-bit value rotated by 2*rot
//   shiftOperand in  12  shifter operand field from the instruction
//   rmVal        in  32  register operand Rm
//   val2         out 32  generated second operand
// ----------------------------------------------------------------------------
module val2_gen
    import ex_pkg::*;
(
    input  logic              memEn,
    input  logic              imm,
    input  logic [11:0]       shiftOperand,
    input  logic [WORD_W-1:0] rmVal,
    output logic [WORD_W-1:0] val2
);

    logic [4:0] shiftAmt;
    logic [4:0] rotAmt;

    assign shiftAmt = shiftOperand[11:7];
    assign rotAmt   = {shiftOperand[11:8], 1'b0};

    // Memory instructions take priority: their offset is used as-is, even if
    // the immediate flag happens to be set. Otherwise either rotate the 8-bit
    // immediate or shift Rm. A zero shift amount leaves Rm untouched for
    // every shift type (no ARM special meanings for #0 here).
    always_comb begin
        val2 = '0;
        if (memEn) begin
            val2 = {20'd0, shiftOperand};
        end else if (imm) begin
            val2 = rotateRight({24'd0, shiftOperand[7:0]}, rotAmt);
        end else begin
            case (shiftOperand[6:5])
                SH_LSL:  val2 = rmVal << shiftAmt;
                SH_LSR:  val2 = rmVal >> shiftAmt;
                SH_ASR:  val2 = $unsigned($signed(rmVal) >>> shiftAmt);
                SH_ROR:  val2 = rotateRight(rmVal, shiftAmt);
                default: val2 = rmVal;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage
// Execute stage of the ARM-subset 5-stage pipeline. Builds Val2, runs the
// ALU, owns the NZCV status register, computes the branch target and drives
// the EX/MEM pipeline register.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   freeze                          hazard stall, holds EX/MEM and status
//   mem_wb_en_in/mem_r_en_in/
//   mem_w_en_in                     control bits from ID/EX
//   exe_cmd_in                      ALU command
//   b_in, s_in                      branch flag, set-flags flag
//   pc_in                           PC+4 of the instruction
//   rn_val_in, rm_val_in            register operands
//   imm_in, shift_operand_in        operand-2 selection and field
//   signed_imm_in                   24-bit branch offset (in words)
//   dest_in                         destination register
//   carry_in                        C flag captured at decode
//   branch_taken, branch_addr       combinational redirect to fetch
//   status                          registered {N,Z,C,V}
//   alu_res_out, st_val_out,
//   dest_out, mem_*_out             registered EX/MEM contents
// ----------------------------------------------------------------------------
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              mem_wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] rn_val_in,
    input  logic [DATA_W-1:0] rm_val_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_in,
    input  logic [3:0]        dest_in,
    input  logic              carry_in,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr,
    output logic [3:0]        status,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] st_val_out,
    output logic [3:0]        dest_out,
    output logic              mem_wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out
);

    logic              memAccess;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] aluRes;
    logic [DATA_W:0]   sum33;
    logic              carryOut;
    logic              overflow;
    logic [3:0]        newFlags;

    assign memAccess = mem_r_en_in | mem_w_en_in;

    val2_gen u_val2 (
        .memEn        (memAccess),
        .imm          (imm_in),
        .shiftOperand (shift_operand_in),
        .rmVal        (rm_val_in),
        .val2         (val2)
    );

    // Branch redirect is purely combinational so fetch can act in the same
    // cycle; the offset is a word count, hence the sign extension and x4.
    // Freeze deliberately has no effect here.
    assign branch_taken = b_in;
    assign branch_addr  = pc_in + {{6{signed_imm_in[23]}}, signed_imm_in, 2'b00};

    // ALU. All arithmetic goes through one 33-bit adder so bit 32 is the
    // carry out. Subtraction is done as A + ~B + 1 (or + carry_in for SBC),
    // which makes bit 32 the ARM-style "not borrow" carry. Logic ops, moves
    // and unknown commands keep the current C and V so only N and Z change.
    always_comb begin
        aluRes   = '0;
        sum33    = '0;
        carryOut = status[FLAG_C];
        overflow = status[FLAG_V];
        case (exe_cmd_in)
            CMD_MOV: aluRes = val2;
            CMD_MVN: aluRes = ~val2;
            CMD_ADD, CMD_ADC: begin
                sum33 = {1'b0, rn_val_in} + {1'b0, val2};
                if (exe_cmd_in == CMD_ADC) begin
                    sum33 = sum33 + {{DATA_W{1'b0}}, carry_in};
                end
                aluRes   = sum33[DATA_W-1:0];
                carryOut = sum33[DATA_W];
                overflow = (rn_val_in[DATA_W-1] == val2[DATA_W-1]) &&
                           (aluRes[DATA_W-1] != rn_val_in[DATA_W-1]);
            end
            CMD_SUB, CMD_SBC: begin
                sum33 = {1'b0, rn_val_in} + {1'b0, ~val2};
                if (exe_cmd_in == CMD_SUB) begin
                    sum33 = sum33 + {{DATA_W{1'b0}}, 1'b1};
                end else begin
                    sum33 = sum33 + {{DATA_W{1'b0}}, carry_in};
                end
                aluRes   = sum33[DATA_W-1:0];
                carryOut = sum33[DATA_W];
                overflow = (rn_val_in[DATA_W-1] != val2[DATA_W-1]) &&
                           (aluRes[DATA_W-1] != rn_val_in[DATA_W-1]);
            end
            CMD_AND: aluRes = rn_val_in & val2;
            CMD_ORR: aluRes = rn_val_in | val2;
            CMD_EOR: aluRes = rn_val_in ^ val2;
            default: aluRes = '0;
        endcase
    end

    // Candidate status word assembled in {N,Z,C,V} order.
    always_comb begin
        newFlags         = '0;
        newFlags[FLAG_N] = aluRes[DATA_W-1];
        newFlags[FLAG_Z] = (aluRes == '0);
        newFlags[FLAG_C] = carryOut;
        newFlags[FLAG_V] = overflow;
    end

    // EX/MEM register and status register. Reset wins over freeze; freeze
    // holds everything including the flags. A flushed (all-zero) slot simply
    // loads zero control bits and, having s_in=0, leaves the flags alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_res_out   <= '0;
            st_val_out    <= '0;
            dest_out      <= '0;
            mem_wb_en_out <= 1'b0;
            mem_r_en_out  <= 1'b0;
            mem_w_en_out  <= 1'b0;
            status        <= '0;
        end else if (!freeze) begin
            alu_res_out   <= aluRes;
            st_val_out    <= rm_val_in;
            dest_out      <= dest_in;
            mem_wb_en_out <= mem_wb_en_in;
            mem_r_en_out  <= mem_r_en_in;
            mem_w_en_out  <= mem_w_en_in;
            if (s_in) begin
                status <= newFlags;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_stage
// Self-checking bench for ex_stage: a table of directed vectors with
// constant expectations, a hand-written freeze/reset sequence, then random
// traffic compared against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst, freeze, wbEn, rEn, wEn, bIn, sIn, immIn, carryIn;
    logic [3:0]  cmd, destIn;
    logic [31:0] pc, rn, rm;
    logic [11:0] shOp;
    logic [23:0] sImm;

    logic        branchTaken, memWbOut, memROut, memWOut;
    logic [31:0] branchAddr, aluResOut, stValOut;
    logic [3:0]  statusOut, destOut;

    int errors = 0;
    int checks = 0;

    // Reference model state (what EX/MEM should hold after the next edge).
    logic [31:0] mRes = '0, mSt = '0;
    logic [3:0]  mDest = '0, mStatus = '0;
    logic [2:0]  mCtrl = '0;

    ex_stage #(.DATA_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .freeze           (freeze),
        .mem_wb_en_in     (wbEn),
        .mem_r_en_in      (rEn),
        .mem_w_en_in      (wEn),
        .exe_cmd_in       (cmd),
        .b_in             (bIn),
        .s_in             (sIn),
        .pc_in            (pc),
        .rn_val_in        (rn),
        .rm_val_in        (rm),
        .imm_in           (immIn),
        .shift_operand_in (shOp),
        .signed_imm_in    (sImm),
        .dest_in          (destIn),
        .carry_in         (carryIn),
        .branch_taken     (branchTaken),
        .branch_addr      (branchAddr),
        .status           (statusOut),
        .alu_res_out      (aluResOut),
        .st_val_out       (stValOut),
        .dest_out         (destOut),
        .mem_wb_en_out    (memWbOut),
        .mem_r_en_out     (memROut),
        .mem_w_en_out     (memWOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, wb, mr, mw;
        logic [3:0]  cmd;
        logic        s, b;
        logic [31:0] pc, rn, rm;
        logic        imm;
        logic [11:0] so;
        logic [23:0] simm;
        logic [3:0]  dest;
        logic        cin;
        logic [31:0] expRes;
        logic [3:0]  expStatus;
        logic [31:0] expBAddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic wb, logic mr, logic mw, logic [3:0] c,
                                logic s, logic b, logic [31:0] p, logic [31:0] a,
                                logic [31:0] m, logic im, logic [11:0] so,
                                logic [23:0] si, logic [3:0] d, logic ci,
                                logic [31:0] eRes, logic [3:0] eSt, logic [31:0] eBa);
        vec_t v;
        v.rst = r; v.wb = wb; v.mr = mr; v.mw = mw; v.cmd = c; v.s = s; v.b = b;
        v.pc = p; v.rn = a; v.rm = m; v.imm = im; v.so = so; v.simm = si;
        v.dest = d; v.cin = ci; v.expRes = eRes; v.expStatus = eSt; v.expBAddr = eBa;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst = v.rst; freeze = 1'b0; wbEn = v.wb; rEn = v.mr; wEn = v.mw;
        cmd = v.cmd; sIn = v.s; bIn = v.b; pc = v.pc; rn = v.rn; rm = v.rm;
        immIn = v.imm; shOp = v.so; sImm = v.simm; destIn = v.dest; carryIn = v.cin;
    endtask

    // Operand 2 by the instruction-set rules: offset, rotated immediate, or
    // a shifted register built one bit position at a time.
    function automatic logic [31:0] modelVal2(logic memEn, logic im, logic [11:0] so,
                                              logic [31:0] m);
        logic [31:0] x;
        int amt;
        if (memEn) return {20'd0, so};
        if (im) begin
            x = {24'd0, so[7:0]};
            for (int k = 0; k < 2 * int'(so[11:8]); k++) x = {x[0], x[31:1]};
            return x;
        end
        amt = int'(so[11:7]);
        x = m;
        case (so[6:5])
            2'd0: x = 32'(longint'(m) * (longint'(1) << amt));
            2'd1: x = m / (32'd1 << amt);
            2'd2: for (int k = 0; k < amt; k++) x = {x[31], x[31:1]};
            default: for (int k = 0; k < amt; k++) x = {x[0], x[31:1]};
        endcase
        return x;
    endfunction

    // ALU by plain wide arithmetic: carry from the unsigned 64-bit result,
    // overflow when the true signed result does not fit in 32 bits.
    task automatic modelAlu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                            input logic ci, input logic [3:0] cur,
                            output logic [31:0] res, output logic [3:0] fl);
        longint ua, ub, sa, sb, sres, brw;
        logic cf, vf;
        ua = longint'(a); ub = longint'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        brw = longint'(!ci);
        cf = cur[1]; vf = cur[0]; sres = 0;
        case (c)
            4'b0010, 4'b0011: begin
                ua = ua + ub + ((c == 4'b0011) ? longint'(ci) : 0);
                sres = sa + sb + ((c == 4'b0011) ? longint'(ci) : 0);
                res = 32'(ua);
                cf = (ua >> 32) != 0;
                vf = sres != longint'($signed(res));
            end
            4'b0100, 4'b0101: begin
                if (c == 4'b0100) brw = 0;
                res = 32'(ua - ub - brw);
                sres = sa - sb - brw;
                cf = ua >= (ub + brw);
                vf = sres != longint'($signed(res));
            end
            4'b0001: res = b;
            4'b1001: res = ~b;
            4'b0110: res = a & b;
            4'b0111: res = a | b;
            4'b1000: res = a ^ b;
            default: res = 32'd0;
        endcase
        fl = {res[31], res == 32'd0, cf, vf};
    endtask

    // Advance the model using whatever is currently on the DUT inputs.
    task automatic modelClock();
        logic [31:0] res;
        logic [3:0]  fl;
        if (rst) begin
            mRes = '0; mSt = '0; mDest = '0; mCtrl = '0; mStatus = '0;
        end else if (!freeze) begin
            modelAlu(cmd, rn, modelVal2(rEn | wEn, immIn, shOp, rm), carryIn, mStatus, res, fl);
            mRes = res; mSt = rm; mDest = destIn; mCtrl = {wbEn, rEn, wEn};
            if (sIn) mStatus = fl;
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " alu_res"}, aluResOut, mRes);
        checkOutput({tag, " status"}, {28'd0, statusOut}, {28'd0, mStatus});
        checkOutput({tag, " st_val"}, stValOut, mSt);
        checkOutput({tag, " dest"}, {28'd0, destOut}, {28'd0, mDest});
        checkOutput({tag, " ctrl"}, {29'd0, memWbOut, memROut, memWOut}, {29'd0, mCtrl});
    endtask

    initial begin
        logic [31:0] expBa;
        int          off;

        // Directed table; expectations come from hand-worked instruction semantics.
        vecs.push_back(mk(1,1,1,0,CMD_ADD,1,1,32'h40,32'h11,32'h22,1,12'h0FF,24'h1,4'h7,1, 32'h0,4'b0000,32'h44));
        vecs.push_back(mk(0,1,0,0,CMD_ADD,1,0,0,32'h7FFFFFFF,0,1,12'h001,0,4'h1,0, 32'h80000000,4'b1001,0));
        vecs.push_back(mk(0,1,0,0,CMD_SUB,1,0,0,32'h5,32'h5,0,12'h000,0,4'h2,0, 32'h0,4'b0110,0));
        vecs.push_back(mk(0,1,0,0,CMD_AND,1,0,0,32'h3,32'h0,1,12'h001,0,4'h3,0, 32'h1,4'b0010,0));
        vecs.push_back(mk(0,1,0,0,CMD_MOV,0,0,0,0,0,1,12'h4FF,0,4'h4,0, 32'hFF000000,4'b0010,0));
        vecs.push_back(mk(0,1,0,0,CMD_MOV,0,0,0,0,32'h80000000,0,12'h0C0,0,4'h5,0, 32'hC0000000,4'b0010,0));
        vecs.push_back(mk(0,1,0,0,CMD_MOV,0,0,0,0,32'h80000000,0,12'h220,0,4'h6,0, 32'h08000000,4'b0010,0));
        vecs.push_back(mk(0,1,0,0,CMD_MOV,0,0,0,0,32'h1,0,12'h0E0,0,4'h7,0, 32'h80000000,4'b0010,0));
        vecs.push_back(mk(0,1,0,0,CMD_MOV,0,0,0,0,32'h12345678,0,12'h060,0,4'h8,0, 32'h12345678,4'b0010,0));
        vecs.push_back(mk(0,1,0,0,CMD_MOV,0,0,0,0,0,1,12'hF01,0,4'h9,0, 32'h4,4'b0010,0));
        vecs.push_back(mk(0,1,0,0,CMD_ADC,1,0,0,32'hFFFFFFFF,0,1,12'h001,0,4'hA,1, 32'h1,4'b0010,0));
        vecs.push_back(mk(0,1,0,0,CMD_SBC,1,0,0,32'h0,0,1,12'h000,0,4'hB,0, 32'hFFFFFFFF,4'b1000,0));
        vecs.push_back(mk(0,1,0,0,CMD_MVN,0,0,0,0,0,1,12'h000,0,4'hC,0, 32'hFFFFFFFF,4'b1000,0));
        vecs.push_back(mk(0,1,0,0,CMD_EOR,0,0,0,32'hF0F0,0,1,12'h0FF,0,4'hD,0, 32'hF00F,4'b1000,0));
        vecs.push_back(mk(0,1,0,0,CMD_ORR,1,0,0,32'hF00,0,1,12'h00F,0,4'hE,0, 32'hF0F,4'b0000,0));
        vecs.push_back(mk(0,1,1,0,CMD_ADD,0,0,0,32'h1000,32'hDEADBEEF,0,12'hABC,0,4'h5,0, 32'h1ABC,4'b0000,0));
        vecs.push_back(mk(0,0,0,1,CMD_ADD,0,0,0,32'h2000,32'hCAFEF00D,1,12'h104,0,4'h6,0, 32'h2104,4'b0000,0));
        vecs.push_back(mk(0,1,0,0,CMD_SUB,1,0,0,32'h80000000,0,1,12'h001,0,4'h1,0, 32'h7FFFFFFF,4'b0011,0));
        vecs.push_back(mk(0,0,0,0,4'h0,0,0,0,0,0,0,12'h000,0,4'h0,0, 32'h0,4'b0011,0));
        vecs.push_back(mk(0,1,0,0,4'hF,0,0,0,32'h5,0,1,12'h001,0,4'h2,0, 32'h0,4'b0011,0));
        vecs.push_back(mk(0,0,0,0,4'h0,0,1,32'h100,0,0,0,12'h000,24'hFFFFFE,4'h0,0, 32'h0,4'b0011,32'hF8));
        vecs.push_back(mk(0,0,0,0,4'h0,0,1,32'h0,0,0,0,12'h000,24'h7FFFFF,4'h0,0, 32'h0,4'b0011,32'h01FFFFFC));
        vecs.push_back(mk(0,0,0,0,4'h0,0,1,32'hFFFFFFFC,0,0,0,12'h000,24'h000001,4'h0,0, 32'h0,4'b0011,32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d branch_taken", i), {31'd0, branchTaken}, {31'd0, vecs[i].b});
            checkOutput($sformatf("row%0d branch_addr", i), branchAddr, vecs[i].expBAddr);
            @(posedge clk);
            #1;
            checkOutput($sformatf("row%0d alu_res", i), aluResOut, vecs[i].expRes);
            checkOutput($sformatf("row%0d status", i), {28'd0, statusOut}, {28'd0, vecs[i].expStatus});
            checkOutput($sformatf("row%0d st_val", i), stValOut, vecs[i].rst ? 32'd0 : vecs[i].rm);
            checkOutput($sformatf("row%0d dest", i), {28'd0, destOut}, vecs[i].rst ? 32'd0 : {28'd0, vecs[i].dest});
            checkOutput($sformatf("row%0d ctrl", i), {29'd0, memWbOut, memROut, memWOut},
                        vecs[i].rst ? 32'd0 : {29'd0, vecs[i].wb, vecs[i].mr, vecs[i].mw});
        end

        // Freeze sequence: load 1+2, then hold for two frozen cycles while a
        // flag-setting ADD and a branch sit on the inputs.
        rst = 0; freeze = 0; wbEn = 1; rEn = 0; wEn = 0; cmd = CMD_ADD; sIn = 1; bIn = 0;
        pc = 0; rn = 32'h1; rm = 32'h0; immIn = 1; shOp = 12'h002; sImm = 0; destIn = 4'h9; carryIn = 0;
        @(posedge clk); #1;
        checkOutput("freeze load res", aluResOut, 32'h3);
        checkOutput("freeze load status", {28'd0, statusOut}, 32'h0);
        freeze = 1; rn = 32'h7FFFFFFF; shOp = 12'h001; destIn = 4'h4;
        bIn = 1; pc = 32'h200; sImm = 24'h1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checkOutput($sformatf("frozen%0d branch_taken", k), {31'd0, branchTaken}, 32'h1);
            checkOutput($sformatf("frozen%0d branch_addr", k), branchAddr, 32'h204);
            @(posedge clk); #1;
            checkOutput($sformatf("frozen%0d res", k), aluResOut, 32'h3);
            checkOutput($sformatf("frozen%0d status", k), {28'd0, statusOut}, 32'h0);
            checkOutput($sformatf("frozen%0d dest", k), {28'd0, destOut}, 32'h9);
        end
        freeze = 0; bIn = 0;
        @(posedge clk); #1;
        checkOutput("release res", aluResOut, 32'h80000000);
        checkOutput("release status", {28'd0, statusOut}, 32'h9);
        checkOutput("release dest", {28'd0, destOut}, 32'h4);
        rst = 1; freeze = 1;
        @(posedge clk); #1;
        checkOutput("rst over freeze res", aluResOut, 32'h0);
        checkOutput("rst over freeze status", {28'd0, statusOut}, 32'h0);
        checkOutput("rst over freeze ctrl", {29'd0, memWbOut, memROut, memWOut}, 32'h0);

        // Random traffic against the reference model; first cycle is a reset.
        for (int i = 0; i < 400; i++) begin
            rst = (i == 0) || ($urandom_range(0, 31) == 0);
            freeze = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 7))
                0: begin rEn = 1; wEn = 0; end
                1: begin rEn = 0; wEn = 1; end
                default: begin rEn = 0; wEn = 0; end
            endcase
            wbEn = 1'($urandom); cmd = 4'($urandom_range(0, 15));
            sIn = 1'($urandom); bIn = 1'($urandom); immIn = 1'($urandom);
            carryIn = 1'($urandom); pc = $urandom; rm = $urandom;
            case ($urandom_range(0, 5))
                0: rn = 32'h0;
                1: rn = 32'hFFFFFFFF;
                2: rn = 32'h80000000;
                3: rn = 32'h7FFFFFFF;
                default: rn = $urandom;
            endcase
            shOp = 12'($urandom); sImm = 24'($urandom); destIn = 4'($urandom);
            #1;
            off = int'($signed(sImm)) * 4;
            expBa = pc + 32'(off);
            checkOutput($sformatf("rand%0d branch_taken", i), {31'd0, branchTaken}, {31'd0, bIn});
            checkOutput($sformatf("rand%0d branch_addr", i), branchAddr, expBa);
            modelClock();
            @(posedge clk); #1;
            checkModel($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the ARM-subset 5-stage pipeline; consumes the ID/EX pipeline register outputs.
- Generates Val2, runs the ALU and computes the branch target.
- Owns the NZCV status register.
- Drives the EX/MEM register contents and feeds branch redirect and flush back to fetch/decode.

Parameters:
- DATA_W, 32, datapath width (fixed at 32; parameterized for readability only)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- freeze  in  1  hazard stall; holds the EX/MEM outputs and the status register
- mem_wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control bits from ID/EX
- exe_cmd_in  in  4  ALU command
- b_in, s_in  in  1 each  branch flag; set-flags flag
- pc_in  in  32  PC+4 of the instruction
- rn_val_in, rm_val_in  in  32 each  register operands
- imm_in  in  1  immediate-operand flag
- shift_operand_in  in  12  shifter operand field
- signed_imm_in  in  24  branch offset
- dest_in  in  4  destination register
- carry_in  in  1  C flag captured at decode
- branch_taken  out  1  combinational, equals b_in; flushes IF/ID and ID/EX
- branch_addr  out  32  combinational branch target
- status  out  4  registered {N,Z,C,V}
- alu_res_out  out  32  registered EX/MEM ALU result
- st_val_out  out  32  registered store data (rm_val)
- dest_out  out  4  registered destination
- mem_wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered control bits

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset: all registered outputs and status are 0 at the first rising clk edge with rst=1. rst has priority over freeze.
- Latency: ID/EX values appear on the EX/MEM outputs 1 cycle later.
- Freeze: when freeze=1 and rst=0, all registered outputs and status hold. branch_taken and branch_addr are not affected.
- Val2 generation:
  - mem_r_en_in | mem_w_en_in: Val2 = zero-extended shift_operand_in[11:0].
  - Else imm_in=1: Val2 = {24'b0, shift_operand_in[7:0]} rotated right by 2*shift_operand_in[11:8].
  - Else: rm_val_in shifted by shift_operand_in[11:7], type shift_operand_in[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes rm unchanged.
- ALU (exe_cmd_in), A = rn_val_in, B = Val2:
  - 0001 MOV: B
  - 1001 MVN: ~B
  - 0010 ADD: A+B
  - 0011 ADC: A+B+carry_in
  - 0100 SUB/CMP: A-B
  - 0101 SBC: A-B-(~carry_in)
  - 0110 AND/TST: A&B
  - 0111 ORR: A|B
  - 1000 EOR: A^B
  - others: result 0
- Flags:
  - N = res[31]; Z = (res==0).
  - C = carry out of the 33-bit add. For subtract, C = NOT borrow, so ARM semantics hold.
  - V = signed overflow for add/sub. Logic ops and MOV/MVN leave C and V unchanged.
- Status update: written on a clk edge only when s_in=1 and freeze=0 and rst=0. When s_in=0 the status holds.
- Bubbles: a flushed ID/EX slot (all zero) must produce all-zero control outputs and no status change.
- Branch target: branch_addr = pc_in + (sign-extended signed_imm_in << 2), modulo 2^32.
- Simultaneous branch and freeze: branch_taken still asserts combinationally. Flushing is the owner's responsibility.

Decomposition:
- Package ex_pkg holds:
  - EXE_CMD localparams (CMD_MOV … CMD_EOR);
  - shift-type constants (SH_LSL/LSR/ASR/ROR);
  - flag bit indices N=3, Z=2, C=1, V=0.
- Sub-module val2_gen: purely combinational Val2 generator, instantiated once. ALU, status register and EX/MEM register stay in ex_stage.

Test Plan:
- Reset: rst=1 with random inputs → all outputs 0 next edge; status=4'b0000.
- ADD with S: rn=32'h7FFFFFFF, imm_in=1, shift_operand=12'h001, cmd=0010, s_in=1 → alu_res_out=32'h80000000, status=4'b1001 (N,V) after 1 cycle.
- SUB/CMP: rn=5, register operand rm=5 LSL 0, cmd=0100, s_in=1 → res=0, status=4'b0110 (Z,C). Then AND with s_in=1 giving 1 → status=4'b0010 (C kept).
- Rotate immediate: shift_operand=12'h4FF, MOV → alu_res_out=32'hFF000000. Register ASR: rm=32'h80000000, shift_operand=12'h0C0 (ASR by 1) → 32'hC0000000.
- Branch: b_in=1, pc_in=32'h100, signed_imm=24'hFFFFFE → branch_taken=1, branch_addr=32'hF8 same cycle.
- Freeze: load ADD result 3, then freeze=1 with a new ADD and s_in=1 for 2 cycles → outputs and status hold. Release → new result 1 cycle later.
